// File: rtl/mtr_cmd_sched_if.sv
// Command handshake between the navigation logic (master) and the motor command scheduler (slave).
// Each command carries a signed 12-bit speed target per wheel.
interface mtr_cmd_sched_if;
  logic               cmd_vld;
  logic               cmd_rdy;
  logic signed [11:0] cmd_lft;
  logic signed [11:0] cmd_rght;

  modport master (output cmd_vld, output cmd_lft, output cmd_rght, input cmd_rdy);
  modport slave  (input cmd_vld, input cmd_lft, input cmd_rght, output cmd_rdy);
endinterface

// File: rtl/mtr_cmd_sched.sv
// Slews wheel speeds toward accepted targets by STEP per tick (4*STEP braking on estop); speeds move one edge after a tick.
// cmd_rdy drops during estop/fault so the source holds the command; LOW_BATT_CUTOFF_EN compiles in the sticky low-battery fault.
module mtr_cmd_sched #(
  parameter int          TICK_DIV  = 1024,
  parameter int          STEP      = 16,
  parameter logic [11:0] VBATT_MIN = 12'hA00
) (
  input  logic               i_clk,
  input  logic               i_rst,
  mtr_cmd_sched_if.slave     cmd_if,
  input  logic               i_estop,
  input  logic [11:0]        i_vbatt,
  output logic signed [11:0] o_lft_spd,
  output logic signed [11:0] o_rght_spd,
  output logic               o_moving,
  output logic               o_done,
  output logic               o_batt_low
);

  localparam int                 TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0]      TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic signed [12:0] STEP_RAMP = 13'(STEP);
  localparam logic signed [12:0] STEP_STOP = 13'(4 * STEP);

  typedef enum logic [2:0] {S_IDLE, S_RAMP, S_HOLD, S_STOP, S_FAULT} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [TW-1:0]      r_tick_cnt;
  logic signed [11:0] r_lft;
  logic signed [11:0] r_rght;
  logic signed [11:0] r_tgt_lft;
  logic signed [11:0] r_tgt_rght;
  logic               r_done;
  logic               w_tick;
  logic               w_accept;
  logic               w_at_tgt;
  logic               w_stopped;
  logic               w_tgt_zero;
  logic               w_done_nxt;
  logic               w_fault_trip;

  // 13-bit difference so a full-scale swing (-2048 -> 2047) cannot wrap; never overshoots the target
  function automatic logic signed [11:0] f_step(input logic signed [11:0] cur,
                                                input logic signed [11:0] tgt,
                                                input logic signed [12:0] lim);
    logic signed [12:0] diff;
    logic signed [12:0] mag;
    logic signed [12:0] nxt;
    diff = {tgt[11], tgt} - {cur[11], cur};
    mag  = diff[12] ? -diff : diff;
    if (mag <= lim)    nxt = {tgt[11], tgt};
    else if (diff[12]) nxt = {cur[11], cur} - lim;
    else               nxt = {cur[11], cur} + lim;
    return nxt[11:0];
  endfunction

  assign w_tick         = (r_tick_cnt == TICK_LAST);
  assign cmd_if.cmd_rdy = ((r_state == S_IDLE) || (r_state == S_RAMP) || (r_state == S_HOLD)) && !i_estop;
  assign w_accept       = cmd_if.cmd_vld && cmd_if.cmd_rdy;
  assign w_at_tgt       = (r_lft == r_tgt_lft) && (r_rght == r_tgt_rght);
  assign w_stopped      = ~|r_lft && ~|r_rght;
  assign w_tgt_zero     = ~|r_tgt_lft && ~|r_tgt_rght;

`ifdef LOW_BATT_CUTOFF_EN
  logic [7:0] r_batt_cnt;
  logic       w_vbatt_low;

  assign w_vbatt_low  = (i_vbatt < VBATT_MIN);
  // trips on the edge where the run of low samples reaches 255
  assign w_fault_trip = w_vbatt_low && (r_batt_cnt >= 8'd254);
  assign o_batt_low   = (r_state == S_FAULT);

  always_ff @(posedge i_clk) begin
    if (i_rst)             r_batt_cnt <= 8'd0;
    else if (!w_vbatt_low) r_batt_cnt <= 8'd0;
    else if (r_batt_cnt != 8'hFF) r_batt_cnt <= r_batt_cnt + 8'd1;
  end
`else
  logic w_unused_vbatt;

  assign w_unused_vbatt = ^{i_vbatt, VBATT_MIN};
  assign w_fault_trip   = 1'b0;
  assign o_batt_low     = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    if ((r_state == S_FAULT) || w_fault_trip) begin
      w_state_nxt = S_FAULT;
    end else if (i_estop) begin
      w_state_nxt = S_STOP;
    end else if (w_accept) begin
      w_state_nxt = S_RAMP;
    end else begin
      case (r_state)
        S_RAMP: begin
          if (w_at_tgt) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = w_tgt_zero ? S_IDLE : S_HOLD;
          end
        end
        S_STOP: begin
          if (w_stopped) w_state_nxt = S_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tick_cnt <= '0;
      r_lft      <= 12'sd0;
      r_rght     <= 12'sd0;
      r_tgt_lft  <= 12'sd0;
      r_tgt_rght <= 12'sd0;
      r_done     <= 1'b0;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
      r_done     <= w_done_nxt;
      if (w_state_nxt == S_FAULT) begin
        r_lft      <= 12'sd0;
        r_rght     <= 12'sd0;
        r_tgt_lft  <= 12'sd0;
        r_tgt_rght <= 12'sd0;
      end else begin
        // a tick coinciding with accept or estop still steps with the state/target of this cycle
        if (w_tick && (r_state == S_RAMP)) begin
          r_lft  <= f_step(r_lft, r_tgt_lft, STEP_RAMP);
          r_rght <= f_step(r_rght, r_tgt_rght, STEP_RAMP);
        end else if (w_tick && (r_state == S_STOP)) begin
          r_lft  <= f_step(r_lft, 12'sd0, STEP_STOP);
          r_rght <= f_step(r_rght, 12'sd0, STEP_STOP);
        end
        if (w_accept) begin
          r_tgt_lft  <= cmd_if.cmd_lft;
          r_tgt_rght <= cmd_if.cmd_rght;
        end else if (w_state_nxt == S_STOP) begin
          r_tgt_lft  <= 12'sd0;
          r_tgt_rght <= 12'sd0;
        end
      end
    end
  end

  assign o_lft_spd  = r_lft;
  assign o_rght_spd = r_rght;
  assign o_moving   = !w_stopped;
  assign o_done     = r_done;

endmodule

// File: doc/mtr_cmd_sched.md
# mtr_cmd_sched

Motor command scheduler between the navigation/command logic and the motor driver. It accepts wheel speed targets over a valid/ready handshake and slews the signed 12-bit `lft_spd`/`rght_spd` inputs of the motor driver toward them at a bounded rate per ramp tick. It also handles emergency stop with a faster braking ramp and, optionally, a sticky low-battery cutoff.

## Interface
- `TICK_DIV`, 1024: clock cycles per ramp tick; must be ≥2.
- `STEP`, 16: maximum per-tick change of each wheel speed; range 1..511.
- `VBATT_MIN`, 12'hA00: low-battery threshold; used only when the cutoff is compiled in.
- `clk` in 1: system clock.
- `rst` in 1: reset. Synchronous, active-high.
- `cmd_vld` in 1: command valid.
- `cmd_rdy` out 1: command ready.
- `cmd_lft` in 12: signed target speed, left wheel.
- `cmd_rght` in 12: signed target speed, right wheel.
- `estop` in 1: emergency stop request. Level-sensitive.
- `vbatt` in 12: battery level, unsigned.
- `lft_spd` out 12: signed left speed to the motor driver. Registered.
- `rght_spd` out 12: signed right speed to the motor driver. Registered.
- `moving` out 1: high when `lft_spd`≠0 or `rght_spd`≠0.
- `done` out 1: one-cycle pulse when both wheels reach their target.
- `batt_low` out 1: sticky low-battery fault flag.

## Operation
- **States:** IDLE, RAMP, HOLD, STOP, FAULT.
- **Reset values:** state IDLE; `lft_spd`=0, `rght_spd`=0; targets 0; tick counter 0; `done`=0; `batt_low`=0.
- **Ready:** `cmd_rdy` = (state ∈ {IDLE, RAMP, HOLD}) & !`estop`. It is combinational from registered state.
- **Accept:** a command is accepted on a clock edge where `cmd_vld` & `cmd_rdy` are both high.
  - Latches `cmd_lft`/`cmd_rght` into the target registers.
  - Next state is RAMP, including retargeting while already in RAMP or HOLD.
  - If `cmd_vld` is high and `cmd_rdy` is low, the command is not consumed; the source holds it.
- **Tick counter:** free-running, 0..`TICK_DIV`-1, then wraps. `tick` is asserted in the cycle the counter equals `TICK_DIV`-1. Commands never reset it.
- **Ramp step:** on each tick in RAMP, independently per wheel:
  - Compute `diff` = target − current in 13-bit signed.
  - If |diff| ≤ `STEP`: current = target.
  - Otherwise: current += sign(diff)·`STEP`.
  - There is no overshoot, so values stay within −2048..2047.
- **Ramp completion:** in RAMP with both wheels equal to target (checked every cycle):
  - `done` pulses for one cycle.
  - Next state is IDLE if both targets are 0, else HOLD.
- **HOLD:** outputs are constant.
- **estop:** while `estop`=1, in any state except FAULT, next state is STOP.
- **STOP:**
  - Targets are forced to 0.
  - Each tick steps both wheels toward 0 by up to 4·`STEP` (13-bit arithmetic).
  - When both wheels are 0 and `estop`=0, next state is IDLE.
  - With both wheels 0 and `estop`=1, the block stays in STOP. `done` is not pulsed from STOP.
- **FAULT:** see Configuration. Outputs are 0, `cmd_rdy`=0, and the state is left only by `rst`.

## Timing
- Output latency: a command accepted at edge N produces its first `lft_spd` change at the edge following the first tick after N.
- Speed update: `lft_spd`/`rght_spd` update at the clock edge that samples `tick`=1.
- Accept and tick in the same cycle:
  - The step uses the old target.
  - The new target applies from the next tick.
  - No `done` pulse occurs in an accept cycle.
- `estop` and `cmd_vld` in the same cycle: no accept, because `cmd_rdy`=0.
- `estop` priority: `estop` asserted mid-RAMP takes effect at the next edge. A tick in that same cycle still applies a normal `STEP` toward the old target.
- `rst` mid-ramp: all outputs are 0 on the next edge. There is no ramp-down.
- `done` timing: `done` is high exactly one cycle, on the cycle after both speeds equal the target.

## Configuration
- Macro: `LOW_BATT_CUTOFF_EN`.
- **Defined:**
  - An 8-bit counter counts consecutive cycles with `vbatt` < `VBATT_MIN`. Any cycle with `vbatt` ≥ `VBATT_MIN` clears it.
  - On reaching 255, the state goes to FAULT at the next edge, with `lft_spd`=`rght_spd`=0 immediately and `batt_low`=1.
  - FAULT has priority over `estop` and accept.
- **Undefined:**
  - `vbatt` is ignored.
  - `batt_low` is tied 0.
  - FAULT is unreachable.

## Test plan
- **Basic ramp:** `TICK_DIV`=4, `STEP`=16. Accept `cmd_lft`=100, `cmd_rght`=−40 from IDLE.
  - Expected `lft_spd`: 16, 32, …, 96, 100 on successive ticks.
  - Expected `rght_spd`: −16, −32, −40.
  - One `done` pulse, then HOLD.
- **Ramp to zero:** from HOLD at (100, 100), accept (0, 0). Speeds ramp down to 0, `done` pulses, state is IDLE, `moving`=0.
- **Retarget:** accept 200 for both wheels. When `lft_spd`=48, accept −32 for both. Speeds reverse to −32 with no `done` pulse before reaching −32.
- **estop:** at (300, −300), assert `estop`.
  - `cmd_rdy`=0.
  - Speeds step by 64 toward 0 and hold 0.
  - After `estop` is released, state is IDLE and `cmd_rdy`=1.
- **Low-battery cutoff (`LOW_BATT_CUTOFF_EN`):**
  - `vbatt`=12'h900 for 254 cycles, then 12'hB00: no fault.
  - Then 12'h900 for 255 cycles: `batt_low`=1, speeds 0, `cmd_rdy`=0 until `rst`.
- **Reset:** assert `rst` mid-ramp at (80, 80). On the next edge outputs are 0, `done`=0, state is IDLE.
